// File: rtl/spi_master_mc_if.sv
// spi_master_mc_if: request/response and SPI pin bundle for spi_master_mc
// Ports (master view): newd, din, cs_sel, mode, miso in; sclk, mosi, cs, dout, done, busy out.
// The slave modport is the mirror image, used by whatever drives requests and models the slaves.
interface spi_master_mc_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CS = 1
);
    localparam int CS_W = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
    logic              newd;
    logic [DATA_W-1:0] din;
    logic [CS_W-1:0]   cs_sel;
    logic [1:0]        mode;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic [NUM_CS-1:0] cs;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              busy;
    modport master (
        input  newd, din, cs_sel, mode, miso,
        output sclk, mosi, cs, dout, done, busy
    );
    modport slave (
        output newd, din, cs_sel, mode, miso,
        input  sclk, mosi, cs, dout, done, busy
    );
endinterface

// File: rtl/spi_master_mc.sv
// spi_master_mc: parametrised full-duplex SPI master, all four modes, multiple active-low chip selects
// Ports: clk; rst (asynchronous, active-low); bus (spi_master_mc_if.master):
//   newd/din/cs_sel/mode start a transfer when busy=0, miso is the slave data in,
//   sclk/mosi/cs drive the slaves, dout/done/busy report the finished transfer.
module spi_master_mc #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 20,
    parameter int NUM_CS    = 1,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic clk,
    input logic rst,
    spi_master_mc_if.master bus
);
    localparam int CS_W  = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int EDGES = 2 * DATA_W;
    localparam int EDG_W = $clog2(EDGES + 1);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t            state;
    logic [DATA_W-1:0] tx, rx, tx_next, rx_next;
    logic [DIV_W-1:0]  div;
    logic [EDG_W-1:0]  edge_cnt;
    logic              cpha;
    logic [NUM_CS-1:0] cs_req;
    logic              half_end, leading, last_edge;
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction
    always_comb begin
        half_end  = div == DIV_W'(CLK_DIV - 1);
        // the edge about to happen is a leading one when an even number have gone by
        leading   = ~edge_cnt[0];
        last_edge = edge_cnt == EDG_W'(EDGES - 1);
        tx_next   = LSB_FIRST ? tx >> 1 : tx << 1;
        rx_next   = LSB_FIRST ? {bus.miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], bus.miso};
        // out-of-range selects fall back to line 0
        cs_req    = ~(NUM_CS'(1) << ((32'(bus.cs_sel) < NUM_CS) ? bus.cs_sel : CS_W'(0)));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            div      <= '0;
            edge_cnt <= '0;
            cpha     <= 1'b0;
            bus.sclk <= 1'b0;
            bus.mosi <= 1'b0;
            bus.cs   <= '1;
            bus.dout <= '0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.newd) begin
                    state    <= SETUP;
                    bus.busy <= 1'b1;
                    bus.cs   <= cs_req;
                    bus.sclk <= bus.mode[1];
                    cpha     <= bus.mode[0];
                    tx       <= bus.din;
                    rx       <= '0;
                    bus.mosi <= first_bit(bus.din);
                    div      <= '0;
                    edge_cnt <= '0;
                end
                SETUP, XFER: begin
                    div <= half_end ? '0 : div + 1'b1;
                    if (half_end) begin
                        bus.sclk <= ~bus.sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        state    <= last_edge ? HOLD : XFER;
                        // capture on leading edges in CPHA=0, trailing in CPHA=1; otherwise shift out,
                        // except the first CPHA=1 leading edge (bit 0 already on mosi) and the final edge
                        if (leading ^ cpha)
                            rx <= rx_next;
                        else if (edge_cnt != '0 && !last_edge) begin
                            tx       <= tx_next;
                            bus.mosi <= first_bit(tx_next);
                        end
                    end
                end
                HOLD: begin
                    div <= half_end ? '0 : div + 1'b1;
                    if (half_end) begin
                        state    <= IDLE;
                        bus.cs   <= '1;
                        bus.mosi <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.dout <= rx;
                        edge_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
